// File: rtl/fd_ctrl_pkg.sv
// Shared types and constants for the divider-sharing arbiter.
package fd_ctrl_pkg;

  // Controller states: wait for a request, launch the divider, wait for it, hand out the result.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } fd_state_t;

  // Response status codes.
  localparam logic [1:0] ST_OK = 2'b00;  // divider produced the result
  localparam logic [1:0] ST_DZ = 2'b01;  // divisor was zero, divider not used
  localparam logic [1:0] ST_TO = 2'b10;  // divider never answered

endpackage

// File: rtl/fd_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping around.
module fd_rr_picker #(
  parameter int  N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  idx,
  output logic             any
);

  logic [N_REQ-1:0] upper_req;
  logic [N_REQ-1:0] search_req;

  // Requests at or above the pointer get priority; only if none exist do we wrap to the bottom.
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_upper
      assign upper_req[gi] = req[gi] & (ID_W'(gi) >= ptr);
    end
  endgenerate

  assign search_req = (|upper_req) ? upper_req : req;
  assign any        = |req;

  // Lowest set bit of the search vector is the winner.
  always_comb begin
    idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (search_req[i]) idx = ID_W'(i);
    end
  end

  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_grant
      assign grant[gi] = any && (idx == ID_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/fd_div_arbiter.sv
// Shares one divider between N_REQ requesters: round-robin grant, single job in flight,
// watchdog on the divider, tagged result returned over a valid/ready port.
module fd_div_arbiter
  import fd_ctrl_pkg::*;
#(
  parameter int  WIDTH   = 16,
  parameter int  N_REQ   = 4,
  parameter int  TIMEOUT = 64,
  localparam int ID_W    = $clog2(N_REQ),
  localparam int WD_W    = $clog2(TIMEOUT + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_dividend,
  input  logic [N_REQ*WIDTH-1:0] req_divisor,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [ID_W-1:0]    rsp_id,
  output logic [WIDTH-1:0]   rsp_quotient,
  output logic [WIDTH-1:0]   rsp_remainder,
  output logic [1:0]         rsp_status,
  output logic               div_start,
  output logic [WIDTH-1:0]   div_dividend,
  output logic [WIDTH-1:0]   div_divisor,
  input  logic               div_done,
  input  logic [WIDTH-1:0]   div_quotient,
  input  logic [WIDTH-1:0]   div_remainder
);

  fd_state_t        state_reg, state_next;
  logic [ID_W-1:0]  ptr_reg;
  logic [WD_W-1:0]  wd_reg;
  logic [ID_W-1:0]  rsp_id_reg;
  logic [WIDTH-1:0] rsp_quotient_reg;
  logic [WIDTH-1:0] rsp_remainder_reg;
  logic [1:0]       rsp_status_reg;
  logic [WIDTH-1:0] div_dividend_reg;
  logic [WIDTH-1:0] div_divisor_reg;

  logic [N_REQ-1:0] pick_grant;
  logic [ID_W-1:0]  pick_idx;
  logic             pick_any;
  logic [WIDTH-1:0] pick_dividend;
  logic [WIDTH-1:0] pick_divisor;
  logic             transfer;
  logic             wd_expired;

  fd_rr_picker #(.N_REQ(N_REQ)) u_picker (
    .req   (req_valid),
    .ptr   (ptr_reg),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign pick_dividend = req_dividend[int'(pick_idx) * WIDTH +: WIDTH];
  assign pick_divisor  = req_divisor[int'(pick_idx) * WIDTH +: WIDTH];

  // Grants are only offered while idle and out of reset, so a requester never sees a phantom handshake.
  assign req_ready  = (rst_n && state_reg == IDLE) ? pick_grant : '0;
  assign transfer   = (state_reg == IDLE) && pick_any;
  // Last permitted BUSY cycle: watchdog has counted TIMEOUT-1 cycles already.
  assign wd_expired = (wd_reg == WD_W'(TIMEOUT - 1));

  assign rsp_valid     = (state_reg == RESP);
  assign rsp_id        = rsp_id_reg;
  assign rsp_quotient  = rsp_quotient_reg;
  assign rsp_remainder = rsp_remainder_reg;
  assign rsp_status    = rsp_status_reg;
  assign div_start     = (state_reg == ISSUE);
  assign div_dividend  = div_dividend_reg;
  assign div_divisor   = div_divisor_reg;

  // Next-state selection; a zero divisor bypasses the divider entirely.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (transfer) state_next = (pick_divisor == '0) ? RESP : ISSUE;
      ISSUE:   state_next = BUSY;
      BUSY:    if (div_done || wd_expired) state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, pointer, watchdog and the operand/result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg         <= IDLE;
      ptr_reg           <= '0;
      wd_reg            <= '0;
      rsp_id_reg        <= '0;
      rsp_quotient_reg  <= '0;
      rsp_remainder_reg <= '0;
      rsp_status_reg    <= ST_OK;
      div_dividend_reg  <= '0;
      div_divisor_reg   <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (transfer) begin
            rsp_id_reg       <= pick_idx;
            div_dividend_reg <= pick_dividend;
            div_divisor_reg  <= pick_divisor;
            if (pick_divisor == '0) begin
              rsp_quotient_reg  <= '1;
              rsp_remainder_reg <= pick_dividend;
              rsp_status_reg    <= ST_DZ;
            end
          end
        end
        ISSUE: wd_reg <= '0;
        BUSY: begin
          wd_reg <= wd_reg + WD_W'(1);
          // A done arriving on the timeout cycle still counts as success.
          if (div_done) begin
            rsp_quotient_reg  <= div_quotient;
            rsp_remainder_reg <= div_remainder;
            rsp_status_reg    <= ST_OK;
          end else if (wd_expired) begin
            rsp_quotient_reg  <= '0;
            rsp_remainder_reg <= '0;
            rsp_status_reg    <= ST_TO;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            ptr_reg <= (rsp_id_reg == ID_W'(N_REQ - 1)) ? '0 : rsp_id_reg + ID_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fd_div_arbiter.sv
// Randomized self-checking bench for fd_div_arbiter with a behavioural divider stub.
module tb_fd_div_arbiter;

  localparam int WIDTH   = 16;
  localparam int N_REQ   = 4;
  localparam int TIMEOUT = 8;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*WIDTH-1:0] req_dividend;
  logic [N_REQ*WIDTH-1:0] req_divisor;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [1:0]             rsp_id;
  logic [WIDTH-1:0]       rsp_quotient;
  logic [WIDTH-1:0]       rsp_remainder;
  logic [1:0]             rsp_status;
  logic                   div_start;
  logic [WIDTH-1:0]       div_dividend;
  logic [WIDTH-1:0]       div_divisor;
  logic                   div_done = 1'b0;
  logic [WIDTH-1:0]       div_quotient = '0;
  logic [WIDTH-1:0]       div_remainder = '0;

  int total = 0;
  int bad   = 0;
  int ptr_m = 0;
  int stub_lat = 0;
  int stub_cnt = 0;
  logic [WIDTH-1:0] stub_a = '0;
  logic [WIDTH-1:0] stub_b = '0;
  logic [WIDTH-1:0] a_m [N_REQ];
  logic [WIDTH-1:0] b_m [N_REQ];

  fd_div_arbiter #(.WIDTH(WIDTH), .N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_dividend  (req_dividend),
    .req_divisor   (req_divisor),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_id        (rsp_id),
    .rsp_quotient  (rsp_quotient),
    .rsp_remainder (rsp_remainder),
    .rsp_status    (rsp_status),
    .div_start     (div_start),
    .div_dividend  (div_dividend),
    .div_divisor   (div_divisor),
    .div_done      (div_done),
    .div_quotient  (div_quotient),
    .div_remainder (div_remainder)
  );

  always #5 clk = ~clk;

  // Pack the per-requester operand arrays onto the flat buses.
  always_comb begin
    req_dividend = '0;
    req_divisor  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_dividend[i*WIDTH +: WIDTH] = a_m[i];
      req_divisor[i*WIDTH +: WIDTH]  = b_m[i];
    end
  end

  // Divider stub: done pulse stub_lat cycles after the start cycle; stub_lat=0 never answers.
  always @(negedge clk) begin
    div_done = 1'b0;
    if (stub_cnt > 0) begin
      stub_cnt = stub_cnt - 1;
      if (stub_cnt == 0) begin
        div_done      = 1'b1;
        div_quotient  = (stub_b == 0) ? '1 : stub_a / stub_b;
        div_remainder = (stub_b == 0) ? stub_a : stub_a % stub_b;
      end
    end
    if (div_start && stub_lat > 0) begin
      stub_cnt = stub_lat;
      stub_a   = div_dividend;
      stub_b   = div_divisor;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Round-robin reference: first requester at or after p, wrapping.
  function automatic int pick(input logic [N_REQ-1:0] m, input int p);
    for (int k = 0; k < N_REQ; k++) begin
      int i;
      i = (p + k) % N_REQ;
      if (m[i]) return i;
    end
    return -1;
  endfunction

  task automatic rand_ops(input int i);
    a_m[i] = 16'($urandom_range(0, 65535));
    if ($urandom_range(0, 7) == 0)      b_m[i] = '0;
    else if ($urandom_range(0, 1) == 1) b_m[i] = 16'($urandom_range(1, 255));
    else                                b_m[i] = 16'($urandom_range(1, 65535));
  endtask

  // One complete job; entered and left at a negedge with the DUT idle.
  task automatic run_job(input logic [N_REQ-1:0] vmask, input int lat, input int hold);
    int g, cyc, exp_lat, starts, start_cyc;
    logic busy_rdy, stable, to;
    logic [WIDTH-1:0] ea, eb, eq, er, q0, r0;
    logic [1:0] es, s0, id0;
    stub_lat  = lat;
    req_valid = vmask;
    g  = pick(vmask, ptr_m);
    ea = a_m[g];
    eb = b_m[g];
    to = (lat == 0) || (lat > TIMEOUT);
    if (eb == 0) begin
      eq = '1; er = ea; es = 2'b01; exp_lat = 1;
    end else if (to) begin
      eq = '0; er = '0; es = 2'b10; exp_lat = 2 + TIMEOUT;
    end else begin
      eq = ea / eb; er = ea % eb; es = 2'b00; exp_lat = 2 + lat;
    end
    #1;
    check_eq("grant", 32'(req_ready), 32'(1) << g);
    cyc = 0; starts = 0; start_cyc = -1; busy_rdy = 1'b0;
    while (!rsp_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) rand_ops(g);
      if (div_start) begin
        starts++;
        if (start_cyc < 0) start_cyc = cyc;
      end
      if (req_ready != 0 && !rsp_valid) busy_rdy = 1'b1;
    end
    check_eq("latency", cyc, exp_lat);
    check_eq("rsp_id", 32'(rsp_id), g);
    check_eq("quotient", 32'(rsp_quotient), 32'(eq));
    check_eq("remainder", 32'(rsp_remainder), 32'(er));
    check_eq("status", 32'(rsp_status), 32'(es));
    if (eb != 0) check_eq("start_cycle", start_cyc, 1);
    if (req_ready != 0) busy_rdy = 1'b1;
    q0 = rsp_quotient; r0 = rsp_remainder; s0 = rsp_status; id0 = rsp_id;
    stable = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_quotient !== q0 || rsp_remainder !== r0 ||
          rsp_status !== s0 || rsp_id !== id0) stable = 1'b0;
      if (div_start) starts++;
      if (req_ready != 0) busy_rdy = 1'b1;
    end
    if (hold > 0) check_eq("hold_stable", 32'(stable), 1);
    check_eq("start_count", starts, (eb == 0) ? 0 : 1);
    check_eq("busy_ready", 32'(busy_rdy), 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check_eq("rsp_drop", 32'(rsp_valid), 0);
    ptr_m = (g + 1) % N_REQ;
    $display("job id=%0d a=%h b=%h lat=%0d hold=%0d q=%h r=%h st=%0d cycles=%0d",
             g, ea, eb, lat, hold, q0, r0, s0, cyc);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic seen;
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      a_m[i] = '0;
      b_m[i] = 16'd1;
    end
    repeat (3) @(negedge clk);
    req_valid = '1;
    #1;
    check_eq("rst_req_ready", 32'(req_ready), 0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 0);
    check_eq("rst_div_start", 32'(div_start), 0);
    check_eq("rst_div_dividend", 32'(div_dividend), 0);
    check_eq("rst_div_divisor", 32'(div_divisor), 0);
    check_eq("rst_rsp_quotient", 32'(rsp_quotient), 0);
    check_eq("rst_rsp_status", 32'(rsp_status), 0);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single requester 1: 100/7.
    a_m[1] = 16'd100; b_m[1] = 16'd7;
    run_job(4'b0010, 3, 0);

    // Divide by zero from requester 2.
    a_m[2] = 16'h1234; b_m[2] = 16'h0000;
    run_job(4'b0100, 3, 0);

    // Reset while BUSY; the stub's late done must be ignored.
    a_m[2] = 16'd500; b_m[2] = 16'd9;
    stub_lat  = 6;
    req_valid = 4'b0100;
    #1;
    check_eq("rb_grant", 32'(req_ready), 32'h4);
    @(negedge clk); req_valid = '0;
    @(negedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    check_eq("rb_rsp_valid", 32'(rsp_valid), 0);
    check_eq("rb_div_dividend", 32'(div_dividend), 0);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid || div_start) seen = 1'b1;
    end
    check_eq("rb_no_response", 32'(seen), 0);
    ptr_m = 0;

    // Fairness: all requesters valid, grants must rotate from 0.
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < N_REQ; i++) rand_ops(i);
      run_job(4'b1111, $urandom_range(1, TIMEOUT), 0);
    end

    // Divider never answers, done exactly on the last BUSY cycle, done one cycle too late.
    b_m[3] = 16'd3;
    run_job(4'b1000, 0, 0);
    a_m[0] = 16'd1000; b_m[0] = 16'd5;
    run_job(4'b0001, TIMEOUT, 0);
    a_m[0] = 16'd77; b_m[0] = 16'd4;
    run_job(4'b0001, TIMEOUT + 1, 0);

    // Consumer stalls for 5 cycles.
    a_m[1] = 16'd999; b_m[1] = 16'd10;
    a_m[2] = 16'd50;  b_m[2] = 16'd3;
    run_job(4'b0110, 2, 5);

    // Random traffic.
    for (int k = 0; k < 30; k++) begin
      for (int i = 0; i < N_REQ; i++) rand_ops(i);
      run_job(4'($urandom_range(1, 15)), $urandom_range(0, TIMEOUT + 1), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
